rec_fn_to_fn_pipe: RTL

- Parametrised, pipelined converter from recoded floating-point (recFN: sign, EXP_W+1-bit exponent, SIG_W-1-bit fraction) to IEEE-754 interchange format (FN).
- Generalises the fixed-width float32 converter to any exponent/significand width.
- Adds a 2-stage valid/ready pipeline with full backpressure, plus per-result classification and NaN-signalling flags.
- Sits at the FPU writeback / store-data boundary, between recoded register-file reads and memory or integer-move paths.

---
 rtl/rec_fn_to_fn_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rec_fn_to_fn_pipe.sv
// Two-stage valid/ready converter from recoded floating point (recFN) to IEEE interchange format.
// Optional macro REC_FN_TO_FN_CANON_NAN_EN replaces every NaN result with the canonical quiet NaN.
module rec_fn_to_fn_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned SIG_W = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [EXP_W+SIG_W:0]   io_in_bits,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [EXP_W+SIG_W-1:0] io_out_bits,
  output logic                   io_out_isNaN,
  output logic                   io_out_isSigNaN,
  output logic                   io_out_isSubnormal
);

  localparam int unsigned FRAC_W = SIG_W - 1;
  localparam logic [EXP_W:0] MIN_NORM  = (EXP_W+1)'((1 << (EXP_W - 1)) + 2);
  localparam logic [EXP_W:0] BIAS_ADJ  = (EXP_W+1)'((1 << (EXP_W - 1)) + 1);
  localparam logic [EXP_W:0] SHIFT_LIM = (EXP_W+1)'(SIG_W);

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_SUBNORMAL,
    CLS_INF,
    CLS_NAN
  } fn_class_e;

  // Stage 1 (decode) state
  logic              s1_valid;
  logic              s1_sign;
  logic [EXP_W:0]    s1_exp;
  logic [FRAC_W-1:0] s1_frac;
  logic [EXP_W:0]    s1_shift;
  fn_class_e         s1_cls;

  logic              s2_advance;
  logic              in_fire;
  logic              s2_load;

  logic              in_sign;
  logic [EXP_W:0]    in_exp;
  logic [FRAC_W-1:0] in_frac;
  logic [2:0]        in_top;
  fn_class_e         in_cls;
  logic [EXP_W:0]    in_shift;

  logic              pk_sign;
  logic [EXP_W-1:0]  pk_exp;
  logic [FRAC_W-1:0] pk_frac;
  logic              pk_nan;
  logic              pk_snan;
  logic              pk_sub;
  logic [FRAC_W-1:0] sub_frac;

  assign s2_advance  = !io_out_valid || io_out_ready;
  assign io_in_ready = !s1_valid || s2_advance;
  assign in_fire     = io_in_valid && io_in_ready;
  assign s2_load     = s1_valid && s2_advance;

  assign in_sign  = io_in_bits[EXP_W+SIG_W];
  assign in_exp   = io_in_bits[EXP_W+SIG_W-1 -: EXP_W+1];
  assign in_frac  = io_in_bits[FRAC_W-1:0];
  assign in_top   = in_exp[EXP_W -: 3];
  assign in_shift = MIN_NORM - in_exp;

  always_comb begin
    in_cls = CLS_NORMAL;
    if (in_top == 3'b000)       in_cls = CLS_ZERO;
    else if (in_top == 3'b110)  in_cls = CLS_INF;
    else if (in_top == 3'b111)  in_cls = CLS_NAN;
    else if (in_exp < MIN_NORM) in_cls = CLS_SUBNORMAL;
  end

  // Shift amounts of SIG_W or more flush to zero instead of wrapping
  always_comb begin
    sub_frac = '0;
    if (s1_shift < SHIFT_LIM) sub_frac = FRAC_W'({1'b1, s1_frac} >> s1_shift);
  end

  always_comb begin
    pk_sign = s1_sign;
    pk_exp  = '0;
    pk_frac = '0;
    pk_nan  = 1'b0;
    pk_snan = 1'b0;
    pk_sub  = 1'b0;
    case (s1_cls)
      CLS_NORMAL: begin
        pk_exp  = EXP_W'(s1_exp - BIAS_ADJ);
        pk_frac = s1_frac;
      end
      CLS_SUBNORMAL: begin
        pk_frac = sub_frac;
        pk_sub  = |sub_frac;
      end
      CLS_INF: pk_exp = '1;
      CLS_NAN: begin
        pk_exp  = '1;
        pk_nan  = 1'b1;
        pk_snan = !s1_frac[FRAC_W-1];
`ifdef REC_FN_TO_FN_CANON_NAN_EN
        pk_sign = 1'b0;
        pk_frac = {1'b1, {(FRAC_W-1){1'b0}}};
`else
        pk_frac = s1_frac;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_shift <= '0;
      s1_cls   <= CLS_ZERO;
    end else begin
      if (io_in_ready) s1_valid <= io_in_valid;
      if (in_fire) begin
        s1_sign  <= in_sign;
        s1_exp   <= in_exp;
        s1_frac  <= in_frac;
        s1_shift <= in_shift;
        s1_cls   <= in_cls;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_out_valid       <= 1'b0;
      io_out_bits        <= '0;
      io_out_isNaN       <= 1'b0;
      io_out_isSigNaN    <= 1'b0;
      io_out_isSubnormal <= 1'b0;
    end else begin
      if (s2_advance) io_out_valid <= s1_valid;
      if (s2_load) begin
        io_out_bits        <= {pk_sign, pk_exp, pk_frac};
        io_out_isNaN       <= pk_nan;
        io_out_isSigNaN    <= pk_snan;
        io_out_isSubnormal <= pk_sub;
      end
    end
  end

endmodule
